// File: rtl/isa_pkg.sv
// Shared ISA definitions for the instruction issuer: opcode encodings,
// issuer state encoding and a saturating counter helper.
package isa_pkg;

    localparam logic [1:0] OP_MOVE = 2'b00;
    localparam logic [1:0] OP_LOAD = 2'b01;
    localparam logic [1:0] OP_ADD  = 2'b10;
    localparam logic [1:0] OP_XOR  = 2'b11;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_IMM  = 1'b1
    } issuer_state_e;

    // Increment that sticks at 255 instead of wrapping
    function automatic logic [7:0] sat_inc8(input logic [7:0] value);
        logic [7:0] result;
        if (value == 8'hFF) begin
            result = value;
        end else begin
            result = value + 8'd1;
        end
        return result;
    endfunction

endpackage

// File: rtl/issue_fifo.sv
// In-order byte FIFO feeding the issuer; DEPTH must be a power of two so the
// pointers wrap naturally. Read data is presented combinationally at the head.
module issue_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [AW:0]      count_r;
    logic             push_ok_s;
    logic             pop_ok_s;

    assign full      = (count_r == FULL_CNT);
    assign empty     = (count_r == '0);
    assign push_ok_s = push && !full;
    assign pop_ok_s  = pop && !empty;
    assign pop_data  = mem_r[rd_ptr_r];

    // Storage array; contents are don't-care until written so it has no reset
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

    // Pointers and occupancy; a push and pop in the same cycle leave count unchanged
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + (AW + 1)'(1);
                2'b01:   count_r <= count_r - (AW + 1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/instr_issuer.sv
// Instruction issuer: pops instruction bytes into ISR on fetch, and pulls the
// trailing immediate of a LOAD into imm. Optional counters: ISSUER_OPCODE_COUNT_EN.
module instr_issuer
    import isa_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       wr_valid,
    input  logic [7:0] wr_data,
    output logic       wr_ready,
    input  logic       fetch_req,
    output logic [7:0] ISR,
    output logic       ir_valid,
    output logic [7:0] imm,
    output logic       imm_valid,
    output logic       stall,
    output logic [7:0] cnt_move,
    output logic [7:0] cnt_load,
    output logic [7:0] cnt_add,
    output logic [7:0] cnt_xor
);

    issuer_state_e state_r;
    issuer_state_e state_nxt_s;
    logic [7:0]    fifo_data_s;
    logic          fifo_full_s;
    logic          fifo_empty_s;
    logic          pop_s;
    logic          issue_s;
    logic          imm_load_s;
    logic          stall_s;
    logic [7:0]    isr_r;
    logic [7:0]    imm_r;
    logic          ir_valid_r;
    logic          imm_valid_r;

    issue_fifo #(
        .DEPTH(DEPTH),
        .WIDTH(8)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (wr_valid),
        .push_data(wr_data),
        .pop      (pop_s),
        .pop_data (fifo_data_s),
        .full     (fifo_full_s),
        .empty    (fifo_empty_s)
    );

    assign wr_ready  = !fifo_full_s;
    assign stall     = stall_s;
    assign ISR       = isr_r;
    assign imm       = imm_r;
    assign ir_valid  = ir_valid_r;
    assign imm_valid = imm_valid_r;

    // Issue control: decide pops, the next state and the stall indication
    always_comb begin
        state_nxt_s = state_r;
        pop_s       = 1'b0;
        issue_s     = 1'b0;
        imm_load_s  = 1'b0;
        stall_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (fetch_req && !fifo_empty_s) begin
                    pop_s   = 1'b1;
                    issue_s = 1'b1;
                    if (fifo_data_s[7:6] == OP_LOAD) begin
                        state_nxt_s = ST_IMM;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end else begin
                    stall_s = fetch_req && fifo_empty_s;
                end
            end
            ST_IMM: begin
                // fetch_req is deliberately ignored while the immediate is owed
                if (!fifo_empty_s) begin
                    pop_s       = 1'b1;
                    imm_load_s  = 1'b1;
                    state_nxt_s = ST_IDLE;
                end else begin
                    stall_s = 1'b1;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State register; reset abandons any LOAD still waiting for its immediate
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Issued-word registers hold between pops; valid flags are single-cycle pulses
    always_ff @(posedge clk) begin
        if (reset) begin
            isr_r       <= 8'h00;
            imm_r       <= 8'h00;
            ir_valid_r  <= 1'b0;
            imm_valid_r <= 1'b0;
        end else begin
            ir_valid_r  <= issue_s;
            imm_valid_r <= imm_load_s;
            if (issue_s) begin
                isr_r <= fifo_data_s;
            end
            if (imm_load_s) begin
                imm_r <= fifo_data_s;
            end
        end
    end

`ifdef ISSUER_OPCODE_COUNT_EN
    logic [7:0] cnt_move_r;
    logic [7:0] cnt_load_r;
    logic [7:0] cnt_add_r;
    logic [7:0] cnt_xor_r;

    // Saturating per-opcode counters, bumped on each instruction issue
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_move_r <= 8'd0;
            cnt_load_r <= 8'd0;
            cnt_add_r  <= 8'd0;
            cnt_xor_r  <= 8'd0;
        end else if (issue_s) begin
            case (fifo_data_s[7:6])
                OP_MOVE: cnt_move_r <= sat_inc8(cnt_move_r);
                OP_LOAD: cnt_load_r <= sat_inc8(cnt_load_r);
                OP_ADD:  cnt_add_r  <= sat_inc8(cnt_add_r);
                OP_XOR:  cnt_xor_r  <= sat_inc8(cnt_xor_r);
                default: cnt_move_r <= cnt_move_r;
            endcase
        end
    end

    assign cnt_move = cnt_move_r;
    assign cnt_load = cnt_load_r;
    assign cnt_add  = cnt_add_r;
    assign cnt_xor  = cnt_xor_r;
`else
    assign cnt_move = 8'd0;
    assign cnt_load = 8'd0;
    assign cnt_add  = 8'd0;
    assign cnt_xor  = 8'd0;
`endif

endmodule

// File: tb/tb_instr_issuer.sv
// Self-checking bench for instr_issuer: a vector table for the main flow, a
// scoreboard of expected issue events, and directed multi-cycle sequences.
module tb_instr_issuer;

    localparam int DEPTH = 8;
`ifdef ISSUER_OPCODE_COUNT_EN
    localparam logic [7:0] CNT_ON = 8'd1;
`else
    localparam logic [7:0] CNT_ON = 8'd0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       wr_valid;
    logic [7:0] wr_data;
    logic       wr_ready;
    logic       fetch_req;
    logic [7:0] ISR;
    logic       ir_valid;
    logic [7:0] imm;
    logic       imm_valid;
    logic       stall;
    logic [7:0] cnt_move;
    logic [7:0] cnt_load;
    logic [7:0] cnt_add;
    logic [7:0] cnt_xor;

    instr_issuer #(.DEPTH(DEPTH)) dut (
        .clk      (clk),
        .reset    (reset),
        .wr_valid (wr_valid),
        .wr_data  (wr_data),
        .wr_ready (wr_ready),
        .fetch_req(fetch_req),
        .ISR      (ISR),
        .ir_valid (ir_valid),
        .imm      (imm),
        .imm_valid(imm_valid),
        .stall    (stall),
        .cnt_move (cnt_move),
        .cnt_load (cnt_load),
        .cnt_add  (cnt_add),
        .cnt_xor  (cnt_xor)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       is_imm;
        logic [7:0] data;
    } ev_t;

    typedef struct {
        logic       wv;
        logic [7:0] wd;
        logic       fr;
        logic       exp_ready;
        logic       exp_stall;
    } vec_t;

    ev_t        sb_q[$];
    vec_t       vt[18];
    int         vectors = 0;
    int         miscompares = 0;
    logic [7:0] exp_isr = 8'h00;
    logic [7:0] exp_imm = 8'h00;
    logic       next_is_imm = 1'b0;

    task automatic check1(input string name, input logic act, input logic exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Record an accepted host byte; its role follows from byte order alone
    task automatic note_write(input logic [7:0] d);
        ev_t e;
        e.is_imm = next_is_imm;
        e.data   = d;
        sb_q.push_back(e);
        if (next_is_imm) begin
            next_is_imm = 1'b0;
        end else begin
            next_is_imm = (d[7:6] == 2'b01);
        end
    endtask

    task automatic drive(input logic wv, input logic [7:0] wd, input logic fr);
        wr_valid  = wv;
        wr_data   = wd;
        fetch_req = fr;
    endtask

    // Advance one clock and score any issue pulse against the queue
    task automatic tick();
        ev_t e;
        @(posedge clk);
        #1;
        if (ir_valid === 1'b1 || imm_valid === 1'b1) begin
            if (sb_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_pulse: ir_valid=%b imm_valid=%b ISR=%h imm=%h, nothing pending",
                         ir_valid, imm_valid, ISR, imm);
            end else begin
                e = sb_q.pop_front();
                check1("pulse_kind_imm", imm_valid, e.is_imm);
                check1("pulse_both", ir_valid & imm_valid, 1'b0);
                if (e.is_imm) begin
                    exp_imm = e.data;
                end else begin
                    exp_isr = e.data;
                end
            end
        end
        check8("isr_value", ISR, exp_isr);
        check8("imm_value", imm, exp_imm);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive(1'b0, 8'h00, 1'b0);
        sb_q.delete();
        exp_isr     = 8'h00;
        exp_imm     = 8'h00;
        next_is_imm = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        check8({tag, "_isr"}, ISR, 8'h00);
        check8({tag, "_imm"}, imm, 8'h00);
        check1({tag, "_ir_valid"}, ir_valid, 1'b0);
        check1({tag, "_imm_valid"}, imm_valid, 1'b0);
        check1({tag, "_wr_ready"}, wr_ready, 1'b1);
        check1({tag, "_stall"}, stall, 1'b0);
        check8({tag, "_cnt_move"}, cnt_move, 8'd0);
        check8({tag, "_cnt_load"}, cnt_load, 8'd0);
        check8({tag, "_cnt_add"}, cnt_add, 8'd0);
        check8({tag, "_cnt_xor"}, cnt_xor, 8'd0);
    endtask

    initial begin
        //          wv    wd     fr    ready stall
        vt[0]  = '{1'b1, 8'h8A, 1'b0, 1'b1, 1'b0}; // ADD
        vt[1]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0};
        vt[2]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0};
        vt[3]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1}; // fetch on empty
        vt[4]  = '{1'b1, 8'h45, 1'b0, 1'b1, 1'b0}; // LOAD
        vt[5]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0};
        vt[6]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1}; // IMM starving
        vt[7]  = '{1'b1, 8'h3C, 1'b1, 1'b1, 1'b1}; // immediate arrives
        vt[8]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0};
        vt[9]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0};
        vt[10] = '{1'b1, 8'hC7, 1'b1, 1'b1, 1'b1}; // XOR, no bypass
        vt[11] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0};
        vt[12] = '{1'b1, 8'h02, 1'b0, 1'b1, 1'b0}; // MOVE
        vt[13] = '{1'b1, 8'h41, 1'b0, 1'b1, 1'b0}; // LOAD
        vt[14] = '{1'b1, 8'hFF, 1'b1, 1'b1, 1'b0}; // immediate
        vt[15] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0};
        vt[16] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0}; // imm pop, fetch ignored
        vt[17] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0};

        do_reset();
        check_reset_state("reset");

        for (int i = 0; i < 18; i++) begin
            drive(vt[i].wv, vt[i].wd, vt[i].fr);
            #1;
            check1($sformatf("vec%0d_wr_ready", i), wr_ready, vt[i].exp_ready);
            check1($sformatf("vec%0d_stall", i), stall, vt[i].exp_stall);
            if (vt[i].wv) begin
                note_write(vt[i].wd);
            end
            tick();
        end
        check8("tbl_cnt_move", cnt_move, CNT_ON * 8'd1);
        check8("tbl_cnt_load", cnt_load, CNT_ON * 8'd2);
        check8("tbl_cnt_add", cnt_add, CNT_ON * 8'd1);
        check8("tbl_cnt_xor", cnt_xor, CNT_ON * 8'd1);

        // Fill to full, then pop while a write is offered and refused
        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b1, 8'(i + 1), 1'b0);
            #1;
            check1($sformatf("fill%0d_wr_ready", i), wr_ready, 1'b1);
            note_write(8'(i + 1));
            tick();
        end
        drive(1'b1, 8'h3F, 1'b1);
        #1;
        check1("full_wr_ready", wr_ready, 1'b0);
        check1("full_stall", stall, 1'b0);
        tick();
        check1("full_pop_ir_valid", ir_valid, 1'b1);
        drive(1'b0, 8'h00, 1'b0);
        #1;
        check1("after_pop_wr_ready", wr_ready, 1'b1);
        tick();
        for (int i = 0; i < DEPTH + 2; i++) begin
            drive(1'b0, 8'h00, 1'b1);
            tick();
        end
        #1;
        check1("drained_stall", stall, 1'b1);
        vectors++;
        if (sb_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain_pending: %0d events outstanding, 0 expected", sb_q.size());
        end

        // Push into an empty FIFO while fetching: issue lands one cycle late
        drive(1'b1, 8'h00, 1'b1);
        #1;
        check1("nobypass_stall", stall, 1'b1);
        note_write(8'h00);
        tick();
        check1("nobypass_early_ir", ir_valid, 1'b0);
        drive(1'b0, 8'h00, 1'b1);
        tick();
        check1("nobypass_ir_valid", ir_valid, 1'b1);
        check8("nobypass_isr", ISR, 8'h00);
        drive(1'b0, 8'h00, 1'b0);
        tick();
        check1("nobypass_pulse_end", ir_valid, 1'b0);

        // Reset while a LOAD waits for its immediate
        drive(1'b1, 8'h45, 1'b0);
        note_write(8'h45);
        tick();
        drive(1'b0, 8'h00, 1'b1);
        tick();
        drive(1'b0, 8'h00, 1'b0);
        #1;
        check1("imm_wait_stall", stall, 1'b1);
        do_reset();
        check_reset_state("midload");
        drive(1'b1, 8'h3C, 1'b0);
        note_write(8'h3C);
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 8'h00, 1'b0);
            tick();
            check1($sformatf("midload_no_imm%0d", i), imm_valid, 1'b0);
        end
        drive(1'b0, 8'h00, 1'b1);
        tick();
        check1("midload_move_ir", ir_valid, 1'b1);

        // Long MOVE stream drives the move counter into saturation
        for (int i = 0; i < 300; i++) begin
            drive(1'b1, {2'b00, i[5:0]}, 1'b1);
            note_write({2'b00, i[5:0]});
            tick();
        end
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 8'h00, 1'b1);
            tick();
        end
        check8("sat_cnt_move", cnt_move, (CNT_ON == 8'd1) ? 8'd255 : 8'd0);
        check8("sat_cnt_load", cnt_load, 8'd0);
        vectors++;
        if (sb_q.size() != 0) begin
            miscompares++;
            $display("FAIL final_pending: %0d events outstanding, 0 expected", sb_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/instr_issuer.md
INSTR_ISSUER -- requirements
Module: instr_issuer

Interface
REQ-001 SHALL have parameter DEPTH, default 8, meaning instruction FIFO entries (power of two, 2..16).
REQ-002 SHALL have clk  input  1  sole clock, all state on rising edge.
REQ-003 SHALL have reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have wr_valid  input  1  host offers a byte.
REQ-005 SHALL have wr_data  input  8  instruction or immediate byte.
REQ-006 SHALL have wr_ready  output  1  FIFO can accept (not full).
REQ-007 SHALL have fetch_req  input  1  controller in FETCH, requests next instruction.
REQ-008 SHALL have ISR  output  8  issued instruction word; opcode = ISR[7:6].
REQ-009 SHALL have ir_valid  output  1  one-cycle pulse: ISR newly loaded.
REQ-010 SHALL have imm  output  8  LOAD immediate byte.
REQ-011 SHALL have imm_valid  output  1  one-cycle pulse: imm newly loaded.
REQ-012 SHALL have stall  output  1  fetch_req pending with no byte available.
REQ-013 SHALL have cnt_move, cnt_load, cnt_add, cnt_xor  output  8 each  issued-opcode counters.

Function
REQ-014 SHALL accept a byte when wr_valid && wr_ready; bytes SHALL leave the FIFO in arrival order.
REQ-015 SHALL keep states IDLE, IMM; IDLE -> IMM only on issuing an opcode LOAD (2'b01); IMM -> IDLE on imm pop.
REQ-016 In IDLE, fetch_req && FIFO non-empty SHALL pop one byte into ISR, pulse ir_valid the following cycle (1-cycle latency).
REQ-017 In IMM, next available byte SHALL pop into imm without fetch_req, imm_valid pulsing the following cycle; fetch_req SHALL be ignored in IMM.
REQ-018 MOVE, ADD, XOR SHALL be single-byte: state stays IDLE.
REQ-019 stall SHALL be combinational: (IDLE && fetch_req && empty) || (IMM && empty).
REQ-020 Full FIFO: wr_ready=0, write dropped by host protocol; simultaneous pop SHALL still proceed, wr_ready rising next cycle.
REQ-021 Empty FIFO with simultaneous push and fetch_req: no bypass; pop SHALL occur the cycle after the push.
REQ-022 Pointers SHALL wrap modulo DEPTH; occupancy count DEPTH+1 states (0..DEPTH).
REQ-023 ISR and imm SHALL hold their value between pops.

Reset
REQ-024 On reset: FIFO empty, pointers 0, state IDLE, ISR=0, imm=0, ir_valid=0, imm_valid=0, counters 0, wr_ready=1.
REQ-025 Reset mid-LOAD (in IMM) SHALL abandon the instruction; no imm_valid SHALL follow.

Configuration
REQ-026 Macro ISSUER_OPCODE_COUNT_EN defined: each cnt_* SHALL increment on issue of its opcode, saturating at 255.
REQ-027 Macro undefined: cnt_* ports SHALL remain present and be driven constant 0, no counter flops.

Structure
REQ-028 Shared package isa_pkg SHALL hold opcode constants (MOVE=00, LOAD=01, ADD=10, XOR=11) and issuer state encoding.
REQ-029 FIFO SHALL be a sub-module issue_fifo (DEPTH x 8, push/pop, full/empty).

Verification
REQ-030 Reset, write 8'h8A (ADD), fetch_req -> ir_valid next cycle, ISR=8'h8A, state IDLE, cnt_add=1 (macro on).
REQ-031 Write 8'h45 (LOAD) only, fetch_req -> ISR=8'h45, stall=1 in IMM; write 8'h3C -> imm=8'h3C, imm_valid pulse, IDLE.
REQ-032 Fill 8 bytes -> wr_ready=0; fetch_req same cycle as further write -> one pop, write ignored, wr_ready=1 next cycle.
REQ-033 Empty FIFO, fetch_req held with write 8'h00 same cycle -> ir_valid two cycles after write, ISR=8'h00.
REQ-034 Reset asserted in IMM -> outputs per REQ-024, no imm_valid; 300 MOVEs -> cnt_move=255 (macro on), 0 (macro off).
